// File: rtl/mem_bist_master.sv
// Memory BIST initiator for the picorv32 native memory bus.
// It runs four passes over a word-aligned region: write a pattern, read and
// compare it, write the inverted pattern, then read and compare that.
// It reports pass/fail, a saturating mismatch count and the first failing address.
module mem_bist_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned WORDS     = 256,
    parameter logic [31:0] SEED      = 32'hA5A5_5A5A,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic        clk,
    input  logic        resn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] err_count,
    output logic [31:0] fail_addr,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    // The wait counter only needs to reach TIMEOUT-1; the next stalled edge aborts.
    localparam int unsigned   TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [15:0]   ILAST = 16'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR0,
        S_RD0,
        S_WR1,
        S_RD1,
        S_FIN
    } state_t;

    state_t        r_state;
    state_t        w_nextState;

    logic [15:0]   r_index;
    logic [TW-1:0] r_tcnt;
    logic          r_valid;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wstrb;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;
    logic          r_timeout;
    logic [15:0]   r_errCount;
    logic [31:0]   r_failAddr;

    logic          w_isWrite;
    logic          w_isInverted;
    logic          w_fire;
    logic          w_expire;
    logic          w_lastWord;
    logic [31:0]   w_wordAddr;
    logic [31:0]   w_pattern;
    logic [31:0]   w_expected;
    logic          w_mismatch;

    assign w_isWrite    = (r_state == S_WR0) || (r_state == S_WR1);
    assign w_isInverted = (r_state == S_WR1) || (r_state == S_RD1);
    assign w_fire       = r_valid && mem_ready;
    assign w_expire     = r_valid && !mem_ready && (r_tcnt == TLAST);
    assign w_lastWord   = (r_index == ILAST);
    assign w_wordAddr   = BASE_ADDR + {14'd0, r_index, 2'b00};
    assign w_pattern    = (w_wordAddr ^ SEED) ^ {32{w_isInverted}};
    assign w_expected   = (r_addr ^ SEED) ^ {32{w_isInverted}};
    assign w_mismatch   = (mem_rdata != w_expected);

    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign timeout   = r_timeout;
    assign err_count = r_errCount;
    assign fail_addr = r_failAddr;
    assign mem_valid = r_valid;
    assign mem_instr = 1'b0;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;

    // State register; reset drops straight back to idle with no retry.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Phase sequencing: advance after the last word completes, abort to FIN on a stall.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: if (start) w_nextState = S_WR0;
            S_WR0: begin
                if (w_expire)                   w_nextState = S_FIN;
                else if (w_fire && w_lastWord)  w_nextState = S_RD0;
            end
            S_RD0: begin
                if (w_expire)                   w_nextState = S_FIN;
                else if (w_fire && w_lastWord)  w_nextState = S_WR1;
            end
            S_WR1: begin
                if (w_expire)                   w_nextState = S_FIN;
                else if (w_fire && w_lastWord)  w_nextState = S_RD1;
            end
            S_RD1: begin
                if (w_expire || (w_fire && w_lastWord)) w_nextState = S_FIN;
            end
            S_FIN:   w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Bus request, word index, stall counter and result bookkeeping.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            r_index    <= 16'd0;
            r_tcnt     <= '0;
            r_valid    <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_wstrb    <= 4'h0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            r_errCount <= 16'd0;
            r_failAddr <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy     <= 1'b1;
                        r_index    <= 16'd0;
                        r_errCount <= 16'd0;
                        r_failAddr <= 32'd0;
                        r_timeout  <= 1'b0;
                        r_pass     <= 1'b0;
                    end
                end
                S_WR0, S_RD0, S_WR1, S_RD1: begin
                    if (!r_valid) begin
                        // Idle gap cycle: launch the next request for the current word.
                        r_valid <= 1'b1;
                        r_addr  <= w_wordAddr;
                        r_wstrb <= w_isWrite ? 4'hF : 4'h0;
                        r_tcnt  <= '0;
                        if (w_isWrite) begin
                            r_wdata <= w_pattern;
                        end
                    end else if (mem_ready) begin
                        r_valid <= 1'b0;
                        r_index <= w_lastWord ? 16'd0 : r_index + 16'd1;
                        if (!w_isWrite && w_mismatch) begin
                            if (r_errCount != 16'hFFFF) begin
                                r_errCount <= r_errCount + 16'd1;
                            end
                            if (r_errCount == 16'd0) begin
                                r_failAddr <= r_addr;
                            end
                        end
                    end else if (w_expire) begin
                        r_valid   <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_FIN: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                    r_pass <= (r_errCount == 16'd0) && !r_timeout;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bist_master.sv
// Directed bench for mem_bist_master with a behavioural memory responder.
// Four words at address 0, seed A5A55A5A, stall limit 15 cycles.
module tb_mem_bist_master;

    logic        clk = 1'b0;
    logic        resn = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [15:0] err_count;
    logic [31:0] fail_addr;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'd0;

    int checks = 0;
    int failures = 0;

    // Responder controls
    bit          neverReady = 1'b0;
    bit          randomDelay = 1'b0;
    bit          checkStable = 1'b0;
    int          fixedDelay = 1;
    logic [31:0] stuckMask = 32'd0;

    // Responder state and observation counters
    logic [31:0] memArray [4];
    bit          pending = 1'b0;
    int          waitCnt = 0;
    int          curDelay = 0;
    logic [31:0] holdAddr;
    logic [31:0] holdData;
    logic [3:0]  holdStrb;
    int          validCycles = 0;
    int          doneCount = 0;
    logic [31:0] logAddr [$];
    logic [31:0] logData [$];
    logic [3:0]  logStrb [$];

    mem_bist_master #(
        .BASE_ADDR(32'h0000_0000),
        .WORDS    (4),
        .SEED     (32'hA5A5_5A5A),
        .TIMEOUT  (15)
    ) dut (
        .clk      (clk),
        .resn     (resn),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .timeout  (timeout),
        .err_count(err_count),
        .fail_addr(fail_addr),
        .mem_valid(mem_valid),
        .mem_instr(mem_instr),
        .mem_ready(mem_ready),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One-cycle start pulse, launched and removed on falling edges
    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
    endtask

    task automatic clearLog();
        logAddr.delete();
        logData.delete();
        logStrb.delete();
        validCycles = 0;
        doneCount = 0;
    endtask

    // Memory responder: raises ready after a delay on the falling edge, drops it after completion
    always @(negedge clk) begin
        if (mem_valid) validCycles++;
        if (done) doneCount++;
        if (mem_ready) begin
            mem_ready = 1'b0;
        end else if (!mem_valid) begin
            pending = 1'b0;
        end else if (!neverReady) begin
            if (!pending) begin
                pending  = 1'b1;
                waitCnt  = 0;
                curDelay = randomDelay ? int'($urandom_range(0, 5)) : fixedDelay;
                holdAddr = mem_addr;
                holdData = mem_wdata;
                holdStrb = mem_wstrb;
            end else if (checkStable) begin
                checks++;
                assert (mem_addr === holdAddr && mem_wdata === holdData && mem_wstrb === holdStrb) else begin
                    failures++;
                    $error("[TB] FAIL stableReq observed=%h/%h/%h expected=%h/%h/%h",
                           mem_addr, mem_wdata, mem_wstrb, holdAddr, holdData, holdStrb);
                end
            end
            if (waitCnt >= curDelay) begin
                mem_ready = 1'b1;
                pending   = 1'b0;
                logAddr.push_back(mem_addr);
                logData.push_back(mem_wdata);
                logStrb.push_back(mem_wstrb);
                if (mem_wstrb == 4'hF) begin
                    memArray[mem_addr[3:2]] = mem_wdata;
                end else begin
                    mem_rdata = memArray[mem_addr[3:2]] & ~stuckMask;
                end
            end else begin
                waitCnt++;
            end
        end
    end

    initial begin
        bit          seen;
        logic [31:0] expWrite [4];
        expWrite = '{32'hA5A55A5A, 32'hA5A55A5E, 32'hA5A55A52, 32'hA5A55A56};

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rstBusy", busy, 1'b0);
        checkOutput("rstDone", done, 1'b0);
        checkOutput("rstPass", pass, 1'b0);
        checkOutput("rstTimeout", timeout, 1'b0);
        checkOutput("rstValid", mem_valid, 1'b0);
        checkOutput("rstInstr", mem_instr, 1'b0);
        checkOutput("rstErr", err_count, 16'd0);
        checkOutput("rstFailAddr", fail_addr, 32'd0);
        checkOutput("rstAddr", mem_addr, 32'd0);
        checkOutput("rstWdata", mem_wdata, 32'd0);
        checkOutput("rstWstrb", mem_wstrb, 4'h0);
        resn = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idleNoStart", busy, 1'b0);

        // Ideal memory, ready one cycle after valid, extra start pulses while busy
        $display("[TB] ideal memory with repeated start");
        fixedDelay = 1;
        clearLog();
        applyStimulus();
        checkOutput("busyAfterStart", busy, 1'b1);
        repeat (4) @(negedge clk);
        applyStimulus();
        repeat (6) @(negedge clk);
        applyStimulus();
        waitDone(300, seen);
        checkOutput("idealDone", seen, 1'b1);
        checkOutput("idealPass", pass, 1'b1);
        checkOutput("idealErr", err_count, 16'd0);
        checkOutput("idealFailAddr", fail_addr, 32'd0);
        checkOutput("idealBusyLow", busy, 1'b0);
        checkOutput("idealTimeout", timeout, 1'b0);
        checkOutput("idealTxnCount", logAddr.size(), 32'd16);
        checkOutput("idealValidCycles", validCycles, 32'd32);
        if (logAddr.size() >= 16) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("wr0Addr%0d", i), logAddr[i], 32'(4 * i));
                checkOutput($sformatf("wr0Data%0d", i), logData[i], expWrite[i]);
                checkOutput($sformatf("wr0Strb%0d", i), logStrb[i], 4'hF);
            end
            checkOutput("rd0Addr0", logAddr[4], 32'h0);
            checkOutput("rd0Strb0", logStrb[4], 4'h0);
            checkOutput("rd0WdataHeld", logData[4], 32'hA5A55A56);
            checkOutput("wr1Addr0", logAddr[8], 32'h0);
            checkOutput("wr1Data0", logData[8], 32'h5A5AA5A5);
            checkOutput("wr1Data3", logData[11], 32'h5A5AA5A9);
            checkOutput("rd1Addr3", logAddr[15], 32'hC);
            checkOutput("rd1Strb3", logStrb[15], 4'h0);
        end
        @(negedge clk);
        checkOutput("doneOnePulse", done, 1'b0);
        checkOutput("singleDone", doneCount, 32'd1);
        checkOutput("passHeld", pass, 1'b1);

        // Bit 2 stuck at 0, zero-wait: RD0 words 1,3 and RD1 words 0,2 mismatch
        $display("[TB] stuck bit 2");
        fixedDelay = 0;
        stuckMask = 32'h4;
        clearLog();
        applyStimulus();
        waitDone(200, seen);
        checkOutput("stuck2Done", seen, 1'b1);
        checkOutput("stuck2Err", err_count, 16'd4);
        checkOutput("stuck2FailAddr", fail_addr, 32'h4);
        checkOutput("stuck2Pass", pass, 1'b0);
        checkOutput("zeroWaitValidCycles", validCycles, 32'd16);

        // Bit 0 stuck at 0: the pattern has bit 0 clear, so only RD1 words 0..3 mismatch
        $display("[TB] stuck bit 0, new start clears results");
        stuckMask = 32'h1;
        applyStimulus();
        checkOutput("restartErrCleared", err_count, 16'd0);
        checkOutput("restartFailCleared", fail_addr, 32'd0);
        checkOutput("restartPassCleared", pass, 1'b0);
        checkOutput("restartBusy", busy, 1'b1);
        waitDone(200, seen);
        checkOutput("stuck0Done", seen, 1'b1);
        checkOutput("stuck0Err", err_count, 16'd4);
        checkOutput("stuck0FailAddr", fail_addr, 32'h0);
        checkOutput("stuck0Pass", pass, 1'b0);

        // Responder never answers: abort after 15 cycles of valid
        $display("[TB] never-ready responder");
        stuckMask = 32'd0;
        neverReady = 1'b1;
        clearLog();
        applyStimulus();
        waitDone(100, seen);
        checkOutput("toDone", seen, 1'b1);
        checkOutput("toFlag", timeout, 1'b1);
        checkOutput("toPass", pass, 1'b0);
        checkOutput("toErr", err_count, 16'd0);
        checkOutput("toValidCycles", validCycles, 32'd15);
        checkOutput("toAddr", mem_addr, 32'h0);
        checkOutput("toNoTxn", logAddr.size(), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("toSticky", timeout, 1'b1);
        checkOutput("toValidLow", mem_valid, 1'b0);

        // Random 0..5 cycle ready delay with request stability checking
        $display("[TB] random wait states");
        neverReady = 1'b0;
        randomDelay = 1'b1;
        checkStable = 1'b1;
        clearLog();
        applyStimulus();
        checkOutput("toClearedOnStart", timeout, 1'b0);
        waitDone(400, seen);
        checkOutput("rndDone", seen, 1'b1);
        checkOutput("rndPass", pass, 1'b1);
        checkOutput("rndErr", err_count, 16'd0);
        checkOutput("rndTxnCount", logAddr.size(), 32'd16);
        randomDelay = 1'b0;
        checkStable = 1'b0;

        // Asynchronous reset while a RD0 request is pending
        $display("[TB] reset during RD0");
        fixedDelay = 3;
        clearLog();
        applyStimulus();
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (mem_valid && mem_wstrb == 4'h0) seen = 1'b1;
        end
        checkOutput("rd0Reached", seen, 1'b1);
        #1 resn = 1'b0;
        #1;
        checkOutput("rstMidValid", mem_valid, 1'b0);
        checkOutput("rstMidBusy", busy, 1'b0);
        checkOutput("rstMidDone", done, 1'b0);
        checkOutput("rstMidErr", err_count, 16'd0);
        checkOutput("rstMidFail", fail_addr, 32'd0);
        @(negedge clk);
        resn = 1'b1;
        validCycles = 0;
        doneCount = 0;
        repeat (10) @(negedge clk);
        checkOutput("postRstIdleBusy", busy, 1'b0);
        checkOutput("postRstNoValid", validCycles, 32'd0);
        checkOutput("postRstNoDone", doneCount, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
